// File: rtl/ifid_hazard.sv
// ifid_hazard: IF/ID pipeline register with load-use stall, branch flush and event counters.
module ifid_hazard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc4_IF,
  input  logic [31:0]      instr_IF,
  input  logic             branch_taken,
  input  logic [2:0]       MemRead_inIDEX,
  input  logic [4:0]       rt_inIDEX,
  output logic [31:0]      instr_inIFID,
  output logic [31:0]      pc4_inIFID,
  output logic             valid_inIFID,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       sa,
  output logic [15:0]      imm16,
  output logic             pc_write,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [31:0]      instr_q, instr_d, pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hazard, stall;
  assign instr_inIFID = instr_q;
  assign pc4_inIFID   = pc4_q;
  assign valid_inIFID = valid_q;
  assign rs           = instr_q[25:21];
  assign rt           = instr_q[20:16];
  assign rd           = instr_q[15:11];
  assign sa           = instr_q[10:6];
  assign imm16        = instr_q[15:0];
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign pc_write     = ~stall;
  assign bubble       = stall | branch_taken | ~valid_q;
  // A flush wins over a stall: the held instruction is wrong-path anyway.
  always_comb begin
    hazard      = valid_q && (MemRead_inIDEX != 3'd0) && (rt_inIDEX != 5'd0) &&
                  (rt_inIDEX == instr_q[25:21] || rt_inIDEX == instr_q[20:16]);
    stall       = hazard && !branch_taken;
    instr_d     = branch_taken ? 32'd0 : stall ? instr_q : instr_IF;
    pc4_d       = (branch_taken || stall) ? pc4_q : pc4_IF;
    valid_d     = branch_taken ? 1'b0 : stall ? valid_q : 1'b1;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall && !(&stall_cnt_q)};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, branch_taken && !(&flush_cnt_q)};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_ifid_hazard.sv
// tb_ifid_hazard: directed and randomized checks of ifid_hazard against an abstract pipeline model.
module tb_ifid_hazard;
  logic        clk = 1'b0, rst_n = 1'b0, branch_taken = 1'b0;
  logic [31:0] pc4_IF = '0, instr_IF = '0;
  logic [2:0]  MemRead_inIDEX = '0;
  logic [4:0]  rt_inIDEX = '0;
  logic [31:0] instr_a, pc4_a, instr_b, pc4_b;
  logic        valid_a, valid_b, pcw_a, pcw_b, bub_a, bub_b;
  logic [4:0]  rs_a, rt_a, rd_a, sa_a, rs_b, rt_b, rd_b, sa_b;
  logic [15:0] imm_a, imm_b, scnt_a, fcnt_a;
  logic [3:0]  scnt_b, fcnt_b;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;
  int          m_stall, m_flush;

  always #5 clk = ~clk;

  ifid_hazard dut_a (.clk(clk), .rst_n(rst_n), .pc4_IF(pc4_IF), .instr_IF(instr_IF),
    .branch_taken(branch_taken), .MemRead_inIDEX(MemRead_inIDEX), .rt_inIDEX(rt_inIDEX),
    .instr_inIFID(instr_a), .pc4_inIFID(pc4_a), .valid_inIFID(valid_a), .rs(rs_a), .rt(rt_a),
    .rd(rd_a), .sa(sa_a), .imm16(imm_a), .pc_write(pcw_a), .bubble(bub_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  ifid_hazard #(.CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .pc4_IF(pc4_IF), .instr_IF(instr_IF),
    .branch_taken(branch_taken), .MemRead_inIDEX(MemRead_inIDEX), .rt_inIDEX(rt_inIDEX),
    .instr_inIFID(instr_b), .pc4_inIFID(pc4_b), .valid_inIFID(valid_b), .rs(rs_b), .rt(rt_b),
    .rd(rd_b), .sa(sa_b), .imm16(imm_b), .pc_write(pcw_b), .bubble(bub_b),
    .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

  function automatic bit m_hazard();
    int f_rs = (m_instr >> 21) % 32;
    int f_rt = (m_instr >> 16) % 32;
    return m_valid && MemRead_inIDEX != 0 && rt_inIDEX != 0 &&
           (rt_inIDEX == f_rs || rt_inIDEX == f_rt);
  endfunction

  function automatic int sat(int v, int mx);
    return v > mx ? mx : v;
  endfunction

  task automatic m_clear();
    m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
  endtask

  // Advance the model by one edge using the inputs now applied, then clock the DUTs.
  task automatic tick();
    bit st;
    st = m_hazard() && !branch_taken;
    if (rst_n) begin
      if (st) m_stall++;
      if (branch_taken) m_flush++;
      if (branch_taken) begin m_instr = 0; m_valid = 0; end
      else if (!st) begin m_instr = instr_IF; m_pc4 = pc4_IF; m_valid = 1; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; instr_IF = 32'h8D280000; pc4_IF = 32'h100;
    tick();
    n_cmp++; if (instr_a !== 32'h8D280000) begin n_bad++; $display("FAIL reset_preload instr got %h exp %h", instr_a, 32'h8D280000); end
    #1 rst_n = 1'b0;
    #1;
    m_clear();
    n_cmp++; if (instr_a !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h exp 0", instr_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", valid_a); end
    n_cmp++; if (bub_a !== 1'b1 || pcw_a !== 1'b1) begin n_bad++; $display("FAIL reset_ctl got bub=%b pcw=%b exp 1 1", bub_a, pcw_a); end
    n_cmp++; if (rs_a !== 0 || rt_a !== 0 || imm_a !== 0 || pc4_a !== 0) begin n_bad++; $display("FAIL reset_fields got rs=%0d rt=%0d imm=%h pc4=%h exp 0", rs_a, rt_a, imm_a, pc4_a); end
    n_cmp++; if (scnt_a !== 0 || fcnt_a !== 0 || scnt_b !== 0 || fcnt_b !== 0) begin n_bad++; $display("FAIL reset_cnt got %0d %0d %0d %0d exp 0", scnt_a, fcnt_a, scnt_b, fcnt_b); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (instr_a !== 32'h8D280000 || valid_a !== 1'b1) begin n_bad++; $display("FAIL reset_release got %h v=%b exp 8d280000 v=1", instr_a, valid_a); end
  endtask

  task automatic test_straight();
    instr_IF = 32'h012A4020; pc4_IF = 32'h4; MemRead_inIDEX = 0; rt_inIDEX = 0;
    tick();
    n_cmp++; if (instr_a !== 32'h012A4020 || pc4_a !== 32'h4) begin n_bad++; $display("FAIL straight_reg got %h/%h exp 012a4020/4", instr_a, pc4_a); end
    n_cmp++; if (rs_a !== 9 || rt_a !== 10 || rd_a !== 8 || sa_a !== 0 || imm_a !== 16'h4020) begin n_bad++; $display("FAIL straight_fields got rs=%0d rt=%0d rd=%0d sa=%0d imm=%h exp 9 10 8 0 4020", rs_a, rt_a, rd_a, sa_a, imm_a); end
    #1;
    n_cmp++; if (pcw_a !== 1'b1 || bub_a !== 1'b0) begin n_bad++; $display("FAIL straight_ctl got pcw=%b bub=%b exp 1 0", pcw_a, bub_a); end
  endtask

  task automatic test_load_use();
    int s0;
    instr_IF = 32'h010B5020; pc4_IF = 32'h8; MemRead_inIDEX = 0;
    tick();
    s0 = scnt_a;
    instr_IF = 32'h01095820; pc4_IF = 32'hC; MemRead_inIDEX = 3'b001; rt_inIDEX = 8;
    #1;
    n_cmp++; if (pcw_a !== 1'b0 || bub_a !== 1'b1) begin n_bad++; $display("FAIL loaduse_ctl got pcw=%b bub=%b exp 0 1", pcw_a, bub_a); end
    tick();
    n_cmp++; if (instr_a !== 32'h010B5020 || pc4_a !== 32'h8) begin n_bad++; $display("FAIL loaduse_hold got %h/%h exp 010b5020/8", instr_a, pc4_a); end
    n_cmp++; if (scnt_a !== 16'(s0 + 1)) begin n_bad++; $display("FAIL loaduse_cnt got %0d exp %0d", scnt_a, s0 + 1); end
    MemRead_inIDEX = 0;
    #1;
    n_cmp++; if (pcw_a !== 1'b1 || bub_a !== 1'b0) begin n_bad++; $display("FAIL loaduse_release got pcw=%b bub=%b exp 1 0", pcw_a, bub_a); end
    tick();
    n_cmp++; if (instr_a !== 32'h01095820 || scnt_a !== 16'(s0 + 1)) begin n_bad++; $display("FAIL loaduse_advance got %h cnt=%0d exp 01095820 cnt=%0d", instr_a, scnt_a, s0 + 1); end
  endtask

  task automatic test_no_false();
    instr_IF = 32'h000B5020; MemRead_inIDEX = 0;
    tick();
    MemRead_inIDEX = 3'b010; rt_inIDEX = 0;
    #1;
    n_cmp++; if (pcw_a !== 1'b1 || bub_a !== 1'b0) begin n_bad++; $display("FAIL nofalse_r0 got pcw=%b bub=%b exp 1 0", pcw_a, bub_a); end
    instr_IF = 32'h010B5020; MemRead_inIDEX = 0;
    tick();
    MemRead_inIDEX = 3'b001; rt_inIDEX = 12;
    #1;
    n_cmp++; if (pcw_a !== 1'b1 || bub_a !== 1'b0) begin n_bad++; $display("FAIL nofalse_r12 got pcw=%b bub=%b exp 1 0", pcw_a, bub_a); end
    MemRead_inIDEX = 0;
  endtask

  task automatic test_flush_vs_stall();
    int s0, f0;
    instr_IF = 32'h010B5020; pc4_IF = 32'h20;
    tick();
    s0 = scnt_a; f0 = fcnt_a;
    MemRead_inIDEX = 3'b001; rt_inIDEX = 8; branch_taken = 1'b1; instr_IF = 32'h12345678; pc4_IF = 32'h24;
    #1;
    n_cmp++; if (pcw_a !== 1'b1 || bub_a !== 1'b1) begin n_bad++; $display("FAIL flush_ctl got pcw=%b bub=%b exp 1 1", pcw_a, bub_a); end
    tick();
    branch_taken = 1'b0; MemRead_inIDEX = 0;
    n_cmp++; if (instr_a !== 0 || valid_a !== 1'b0 || pc4_a !== 32'h20) begin n_bad++; $display("FAIL flush_reg got %h v=%b pc4=%h exp 0 v=0 pc4=20", instr_a, valid_a, pc4_a); end
    n_cmp++; if (fcnt_a !== 16'(f0 + 1) || scnt_a !== 16'(s0)) begin n_bad++; $display("FAIL flush_cnt got f=%0d s=%0d exp f=%0d s=%0d", fcnt_a, scnt_a, f0 + 1, s0); end
    #1;
    n_cmp++; if (bub_a !== 1'b1) begin n_bad++; $display("FAIL flush_filler_bubble got %b exp 1", bub_a); end
  endtask

  task automatic test_saturation();
    instr_IF = 32'h010B5020; MemRead_inIDEX = 0;
    tick();
    MemRead_inIDEX = 3'b100; rt_inIDEX = 11;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (scnt_b !== 4'd15) begin n_bad++; $display("FAIL sat_cnt4 got %0d exp 15", scnt_b); end
    n_cmp++; if (scnt_a !== 16'(sat(m_stall, 65535))) begin n_bad++; $display("FAIL sat_cnt16 got %0d exp %0d", scnt_a, m_stall); end
    tick();
    n_cmp++; if (scnt_b !== 4'd15 || instr_b !== 32'h010B5020) begin n_bad++; $display("FAIL sat_hold got %0d %h exp 15 010b5020", scnt_b, instr_b); end
    MemRead_inIDEX = 0;
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      instr_IF = $urandom; pc4_IF = $urandom;
      branch_taken = ($urandom_range(0, 7) == 0);
      MemRead_inIDEX = $urandom_range(0, 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      r = $urandom_range(0, 2);
      rt_inIDEX = r == 0 ? 5'((m_instr >> 21) % 32) : r == 1 ? 5'((m_instr >> 16) % 32) : 5'($urandom);
      #1;
      n_cmp++; if (pcw_a !== !(m_hazard() && !branch_taken) || bub_a !== ((m_hazard() && !branch_taken) || branch_taken || !m_valid)) begin n_bad++; $display("FAIL rnd_ctl[%0d] got pcw=%b bub=%b", i, pcw_a, bub_a); end
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1 m_clear();
        rst_n = 1'b1;
      end
      tick();
      n_cmp++; if (instr_a !== m_instr || pc4_a !== m_pc4 || valid_a !== m_valid) begin n_bad++; $display("FAIL rnd_reg[%0d] got %h/%h/%b exp %h/%h/%b", i, instr_a, pc4_a, valid_a, m_instr, m_pc4, m_valid); end
      n_cmp++; if (rd_a !== 5'((m_instr >> 11) % 32) || sa_a !== 5'((m_instr >> 6) % 32) || imm_a !== 16'(m_instr % 65536)) begin n_bad++; $display("FAIL rnd_fields[%0d] got rd=%0d sa=%0d imm=%h", i, rd_a, sa_a, imm_a); end
      n_cmp++; if (scnt_a !== 16'(sat(m_stall, 65535)) || fcnt_a !== 16'(sat(m_flush, 65535)) || scnt_b !== 4'(sat(m_stall, 15)) || fcnt_b !== 4'(sat(m_flush, 15))) begin n_bad++; $display("FAIL rnd_cnt[%0d] got %0d %0d %0d %0d exp %0d %0d", i, scnt_a, fcnt_a, scnt_b, fcnt_b, m_stall, m_flush); end
    end
    branch_taken = 1'b0; MemRead_inIDEX = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_clear();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_straight();
    test_load_use();
    test_no_false();
    test_flush_vs_stall();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
